// File: rtl/register_file_param.sv
// rtl/register_file_param.sv - parametrised register file with clear sequencer, zero register and write bypass
// Ports:
//   clk      clock, all state on rising edge
//   rst      synchronous reset, active-high; starts a clear sequence
//   clr_req  pulse to start a clear sequence (ignored while busy)
//   busy     high while the clear sequence is zeroing entries
//   wr_en    write strobe, wr_addr/wr_data the single write port
//   rd_addr  NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  NUM_RD packed combinational read data, port i at [i*DATA_W +: DATA_W]
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra counter bit so the terminal compare and the increment past it never wrap.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W:0]   clr_cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign busy  = (state == ST_CLEAR);
  assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_next = clr_cnt + CNT_ONE;
      if (clr_cnt == CNT_LAST) begin
        state_next = ST_IDLE;
      end
    end else if (clr_req) begin
      state_next   = ST_CLEAR;
      clr_cnt_next = '0;
    end
  end

  // Storage has no reset of its own; the sequencer zeroes one entry per cycle.
  // A write presented alongside rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    // Priority: busy, then zero register, then same-cycle write bypass, then storage.
    assign rd_data[i*DATA_W +: DATA_W] =
        busy                                      ? '0 :
        (ZERO_REG && (addr == '0))                ? '0 :
        (BYPASS && wr_en && (wr_addr == addr))    ? wr_data :
                                                    mem[addr];
  end

endmodule

// File: tb/tb_register_file_param.sv
// tb/tb_register_file_param.sv - randomized self-checking bench for register_file_param
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;

  logic        s_rst = 1'b0;
  logic        s_clr_req = 1'b0;
  logic        s_wr_en = 1'b0;
  logic [2:0]  s_wr_addr = '0;
  logic [15:0] s_wr_data = '0;
  logic [11:0] s_rd_addr = '0;
  logic [63:0] s_rd_data;
  logic        s_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [32];
  int          ref_busy_left = 0;

  always #5 clk = ~clk;

  register_file_param dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a)
  );

  register_file_param #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b)
  );

  register_file_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b0)) dut_s (
    .clk(clk), .rst(s_rst), .clr_req(s_clr_req), .busy(s_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ref_busy_left = 32;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (ref_busy_left > 0) return '0;
    if (a == 5'd0) return '0;
    if (byp && wr_en && (wr_addr == a)) return wr_data;
    return ref_mem[a];
  endfunction

  // Check all outputs of both default-width DUTs, clock once, advance the model,
  // then drop the pulse-style inputs.
  task automatic step();
    #1;
    check("busy_a", 64'(busy_a), 64'(ref_busy_left > 0));
    check("busy_b", 64'(busy_b), 64'(ref_busy_left > 0));
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rd_a%0d", p), 64'(rd_data_a[p*32 +: 32]), 64'(exp_rd(rd_addr[p*5 +: 5], 1'b1)));
      check($sformatf("rd_b%0d", p), 64'(rd_data_b[p*32 +: 32]), 64'(exp_rd(rd_addr[p*5 +: 5], 1'b0)));
    end
    @(posedge clk);
    if (rst) model_clear();
    else if (ref_busy_left > 0) ref_busy_left--;
    else if (clr_req) model_clear();
    else if (wr_en && wr_addr != 5'd0) ref_mem[wr_addr] = wr_data;
    @(negedge clk);
    rst = 1'b0;
    clr_req = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      check(tag, rd_data_a, 64'd0);
      step();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(busy_a), 64'd1);
    count_busy(n);
    check("reset_clear_len", 64'(n), 64'd32);
    read_all_zero("reset_zero");

    // Write then read on both ports.
    rd_addr = {5'd5, 5'd5};
    do_write(5'd5, 32'hDEADBEEF);
    #1;
    check("r5_port0", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
    check("r5_port1", 64'(rd_data_a[63:32]), 64'hDEADBEEF);
    step();

    // Zero register drops writes.
    rd_addr = '0;
    do_write(5'd0, 32'h1234);
    #1;
    check("r0_zero", 64'(rd_data_a[31:0]), 64'd0);
    step();

    // Bypass on vs off.
    do_write(5'd7, 32'h11111111);
    rd_addr = {5'd7, 5'd0};
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
    check("bypass_on", 64'(rd_data_a[63:32]), 64'hA5A5A5A5);
    check("bypass_off", 64'(rd_data_b[63:32]), 64'h11111111);
    step();
    #1;
    check("r7_after_a", 64'(rd_data_a[63:32]), 64'hA5A5A5A5);
    check("r7_after_b", 64'(rd_data_b[63:32]), 64'hA5A5A5A5);

    // Writes while busy are dropped.
    clr_req = 1'b1;
    step();
    rd_addr = {5'd3, 5'd3};
    do_write(5'd3, 32'h55);
    count_busy(n);
    #1;
    check("busy_write_dropped", 64'(rd_data_a[31:0]), 64'd0);
    do_write(5'd3, 32'h55);
    #1;
    check("idle_write_kept", 64'(rd_data_a[31:0]), 64'h55);
    step();

    // Fill, clear, second clr_req mid-run must not extend.
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'(a));
    rd_addr = {5'd31, 5'd9};
    #1;
    check("fill_r9", 64'(rd_data_a[31:0]), 64'd9);
    clr_req = 1'b1;
    step();
    repeat (5) step();
    clr_req = 1'b1;
    step();
    count_busy(n);
    check("second_req_no_extend", 64'(n), 64'd26);
    read_all_zero("clr_zero");

    // rst during the 10th busy cycle restarts the count.
    clr_req = 1'b1;
    step();
    repeat (9) step();
    rst = 1'b1;
    step();
    count_busy(n);
    check("rst_restart_len", 64'(n), 64'd32);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_addr = 10'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[9:5] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wr_addr;
      clr_req = ($urandom_range(0, 79) == 0);
      rst     = ($urandom_range(0, 249) == 0);
      step();
    end

    // Parameter sweep instance: 8 entries, 4 ports, 16 bits, no zero register.
    s_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0;
    n = 0;
    while (s_busy && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("sweep_clear_len", 64'(n), 64'd8);
    s_rd_addr = '0;
    #1;
    check("sweep_zero", s_rd_data, 64'd0);
    s_wr_en = 1'b1; s_wr_addr = 3'd0; s_wr_data = 16'hBEEF;
    #1;
    check("sweep_bypass_p0", 64'(s_rd_data[15:0]), 64'hBEEF);
    @(posedge clk);
    @(negedge clk);
    s_wr_en = 1'b0;
    #1;
    for (int p = 0; p < 4; p++)
      check($sformatf("sweep_r0_p%0d", p), 64'(s_rd_data[p*16 +: 16]), 64'hBEEF);
    s_wr_en = 1'b1; s_wr_addr = 3'd5; s_wr_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    s_wr_en = 1'b0;
    s_rd_addr = {3'd5, 3'd0, 3'd5, 3'd0};
    #1;
    check("sweep_mixed", s_rd_data, 64'h1234_BEEF_1234_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
